multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM for the multi-cycle RV32I datapath. It drives the shared ALU's `ALUcontrol` and operand selects, and it consumes the ALU's `zero` flag to resolve branches. It sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction. It supports lw, sw, R-type ALU, I-type ALU, beq/bne and jal, and handles a memory-ready handshake on every memory access.

## Interface
Parameters:
- none (the encodings below are fixed)

Ports:
- `clk`  in  1  system clock; all state changes occur on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  instruction[6:0], taken from the instruction register.
- `funct3`  in  3  instruction[14:12].
- `funct7b5`  in  1  instruction[30].
- `zero`  in  1  ALU result-equals-zero flag.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  data memory write strobe.
- `IRWrite`  out  1  instruction register and OldPC enable.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUresult.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ImmSrc`  out  2  immediate format select: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUcontrol`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.

## Operation
State register:
- Four bits, asynchronously reset to FETCH.
- In every state, any output not listed below is 0.

States, outputs and transitions:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=1 and PCUpdate=1 only while `mem_ready`=1.
  - Goes to DECODE when `mem_ready`=1; otherwise holds in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which computes the branch target.
  - op 0000011 or 0100011 → MEMADR.
  - op 0110011 → EXECR.
  - op 0010011 → EXECI.
  - op 1100011 → BRANCH.
  - op 1101111 → JAL.
  - Any other opcode → FETCH; the instruction is treated as a no-op.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - op[5]=0 → MEMREAD; op[5]=1 → MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1.
  - Goes to MEMWB when `mem_ready`=1; otherwise holds.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - MemWrite stays asserted until `mem_ready`=1, then → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.

PCWrite:
- PCWrite = PCUpdate | (Branch & (zero ^ funct3[0])).
- This gives taken-on-zero for beq and taken-on-nonzero for bne.

ALU decode (combinational from ALUOp, funct3, op[5], funct7b5):
- ALUOp=00 → 000 (add).
- ALUOp=01 → 001 (sub).
- ALUOp=10:
  - funct3 000 → 001 if (op[5] & funct7b5), else 000.
  - funct3 010 → 101 (slt).
  - funct3 110 → 011 (or).
  - funct3 111 → 010 (and).
  - Any other funct3 → 000.

ImmSrc (combinational from op):
- 0100011 → 01.
- 1100011 → 10.
- 1101111 → 11.
- Anything else → 00.

## Timing
- All control outputs are combinational from the registered state plus the instruction fields and `zero`/`mem_ready`. There are no output registers.
- Reset:
  - `rst_n`=0 forces FETCH immediately, mid-instruction included.
  - During reset, outputs equal FETCH decode with `mem_ready` gating. With `mem_ready`=0: all enables are 0, ResultSrc=10, ALUSrcB=10.
  - The first edge after `rst_n` rises evaluates FETCH.
- Latency, counted as cycles from FETCH entry to the next FETCH entry with `mem_ready` always 1:
  - lw 5, sw 4, R-type 4, I-type 4, jal 4, branch 3, unsupported opcode 2.
- Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle; the outputs are unchanged during the stall.
- `mem_ready` is ignored in all other states.

## Test plan
- Reset mid-MEMREAD: assert `rst_n`=0 while in MEMREAD → state is FETCH with no clock edge needed; RegWrite=0; after release, IRWrite=1 on the first cycle with `mem_ready`=1.
- R-type sub: op=0110011, funct3=000, funct7b5=1 → EXECR cycle shows ALUcontrol=001, ALUSrcA=10, ALUSrcB=00; ALUWB cycle shows RegWrite=1, ResultSrc=00; next FETCH after 4 cycles.
- beq/bne: op=1100011 in BRANCH state.
  - funct3=000, zero=1 → PCWrite=1; zero=0 → PCWrite=0.
  - funct3=001 inverts both results.
  - ALUcontrol=001 in every case.
- lw with stalls: `mem_ready`=0 for 2 cycles in FETCH and 3 cycles in MEMREAD → total 10 cycles; IRWrite pulses exactly once; RegWrite pulses once with ResultSrc=01.
- sw then jal: sw shows MemWrite=1, AdrSrc=1, ImmSrc=01 in MEMWRITE. jal shows PCWrite=1, ALUSrcA=01, ALUSrcB=10 in JAL, then RegWrite=1 in ALUWB; ImmSrc=11.
- I-type decode: funct3 = 010, 110, 111, 000 with funct7b5=1 → ALUcontrol = 101, 011, 010, 000 respectively (add, not sub, for I-type). Unsupported op 0000000 → DECODE→FETCH with no write enables.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The controller (master) reads instruction fields and the status flags and
// drives every datapath select and enable.
interface multicycle_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUcontrol;

   modport master (
      input  op, funct3, funct7b5, zero, mem_ready,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUcontrol
   );

   modport slave (
      output op, funct3, funct7b5, zero, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUcontrol
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle RV32I datapath (lw, sw, R/I ALU,
// beq/bne, jal). Outputs decode combinationally from the state register;
// memory states hold until the memory signals completion.
module multicycle_ctrl (
   input  logic                clk,
   input  logic                rst_n,
   multicycle_ctrl_if.master   bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_JAL      = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t     state_reg;
   logic [1:0] alu_op;
   logic       pc_update;
   logic       branch;

   // State sequencing; reset aborts any instruction in flight back to FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_FETCH;
      end else begin
         case (state_reg)
            S_FETCH:    if (bus.mem_ready) state_reg <= S_DECODE;
            S_DECODE: begin
               case (bus.op)
                  OP_LOAD, OP_STORE: state_reg <= S_MEMADR;
                  OP_RTYPE:          state_reg <= S_EXECR;
                  OP_ITYPE:          state_reg <= S_EXECI;
                  OP_BRANCH:         state_reg <= S_BRANCH;
                  OP_JAL:            state_reg <= S_JAL;
                  default:           state_reg <= S_FETCH;
               endcase
            end
            S_MEMADR:   state_reg <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_reg <= S_MEMWB;
            S_MEMWB:    state_reg <= S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_reg <= S_FETCH;
            S_EXECR:    state_reg <= S_ALUWB;
            S_EXECI:    state_reg <= S_ALUWB;
            S_JAL:      state_reg <= S_ALUWB;
            S_ALUWB:    state_reg <= S_FETCH;
            S_BRANCH:   state_reg <= S_FETCH;
            default:    state_reg <= S_FETCH;
         endcase
      end
   end

   // Per-state datapath selects and enables; anything not set stays 0.
   always_comb begin
      bus.AdrSrc    = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.RegWrite  = 1'b0;
      bus.ResultSrc = 2'b00;
      bus.ALUSrcA   = 2'b00;
      bus.ALUSrcB   = 2'b00;
      alu_op        = 2'b00;
      pc_update     = 1'b0;
      branch        = 1'b0;
      case (state_reg)
         S_FETCH: begin
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            bus.IRWrite   = bus.mem_ready;
            pc_update     = bus.mem_ready;
         end
         S_DECODE: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            bus.AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            bus.ResultSrc = 2'b01;
            bus.RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            bus.AdrSrc   = 1'b1;
            bus.MemWrite = 1'b1;
         end
         S_EXECR: begin
            bus.ALUSrcA = 2'b10;
            alu_op      = 2'b10;
         end
         S_EXECI: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            alu_op      = 2'b10;
         end
         S_JAL: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
            pc_update   = 1'b1;
         end
         S_ALUWB: begin
            bus.RegWrite = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA = 2'b10;
            alu_op      = 2'b01;
            branch      = 1'b1;
         end
         default: ;
      endcase
   end

   // funct3[0] distinguishes bne from beq, so it inverts the zero test.
   always_comb begin
      bus.PCWrite = pc_update | (branch & (bus.zero ^ bus.funct3[0]));
   end

   // ALU operation; only R-type with funct7b5 set selects subtract.
   always_comb begin
      bus.ALUcontrol = 3'b000;
      case (alu_op)
         2'b01: bus.ALUcontrol = 3'b001;
         2'b10: begin
            case (bus.funct3)
               3'b000:  bus.ALUcontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
               3'b010:  bus.ALUcontrol = 3'b101;
               3'b110:  bus.ALUcontrol = 3'b011;
               3'b111:  bus.ALUcontrol = 3'b010;
               default: bus.ALUcontrol = 3'b000;
            endcase
         end
         default: bus.ALUcontrol = 3'b000;
      endcase
   end

   // Immediate format follows the opcode alone.
   always_comb begin
      case (bus.op)
         OP_STORE:  bus.ImmSrc = 2'b01;
         OP_BRANCH: bus.ImmSrc = 2'b10;
         OP_JAL:    bus.ImmSrc = 2'b11;
         default:   bus.ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes a hand-computed
// control vector for every cycle it stimulates, the monitor pops and compares
// on the falling edge.
// Vector layout: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA
// ALUSrcB ImmSrc ALUcontrol.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [15:0] got;
   assign got = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                 bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUcontrol};

   // Monitor: compare whatever the driver queued for this cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.tag, got, e.val);
         end else begin
            $display("ok   %s: %b", e.tag, got);
         end
      end
   end

   // Queue one cycle's expectation, then advance to just after the next edge.
   task automatic chk(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      bus.op       = o;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
   endtask

   typedef struct { logic [2:0] f3; logic z; logic pcw; } br_t;
   typedef struct { logic [2:0] f3; logic [2:0] alu; } it_t;

   br_t br_tab[4];
   it_t it_tab[4];

   initial begin
      br_tab[0] = '{3'b000, 1'b1, 1'b1};
      br_tab[1] = '{3'b000, 1'b0, 1'b0};
      br_tab[2] = '{3'b001, 1'b1, 1'b0};
      br_tab[3] = '{3'b001, 1'b0, 1'b1};
      it_tab[0] = '{3'b010, 3'b101};
      it_tab[1] = '{3'b110, 3'b011};
      it_tab[2] = '{3'b111, 3'b010};
      it_tab[3] = '{3'b000, 3'b000};

      rst_n         = 1'b0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      set_instr(7'b0000000, 3'b000, 1'b0);
      @(posedge clk);
      #1;

      // Reset state: FETCH decode with mem_ready low
      chk("reset0", 16'b0_0_0_0_0_10_00_10_00_000);
      chk("reset1", 16'b0_0_0_0_0_10_00_10_00_000);
      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;

      // R-type sub: 4 cycles
      set_instr(7'b0110011, 3'b000, 1'b1);
      chk("sub_fetch",  16'b1_0_0_1_0_10_00_10_00_000);
      chk("sub_decode", 16'b0_0_0_0_0_00_01_01_00_000);
      chk("sub_execr",  16'b0_0_0_0_0_00_10_00_00_001);
      chk("sub_aluwb",  16'b0_0_0_0_1_00_00_00_00_000);

      // beq / bne with both zero values: 3 cycles each
      for (int i = 0; i < 4; i++) begin
         set_instr(7'b1100011, br_tab[i].f3, 1'b0);
         bus.zero = br_tab[i].z;
         chk($sformatf("br%0d_fetch", i),  16'b1_0_0_1_0_10_00_10_10_000);
         chk($sformatf("br%0d_decode", i), 16'b0_0_0_0_0_00_01_01_10_000);
         chk($sformatf("br%0d_branch", i), {br_tab[i].pcw, 15'b0_0_0_0_00_10_00_10_001});
      end
      bus.zero = 1'b0;

      // lw with 2 FETCH stalls and 3 MEMREAD stalls: 10 cycles
      set_instr(7'b0000011, 3'b010, 1'b0);
      bus.mem_ready = 1'b0;
      chk("lw_fstall0", 16'b0_0_0_0_0_10_00_10_00_000);
      chk("lw_fstall1", 16'b0_0_0_0_0_10_00_10_00_000);
      bus.mem_ready = 1'b1;
      chk("lw_fetch",   16'b1_0_0_1_0_10_00_10_00_000);
      bus.mem_ready = 1'b0;
      chk("lw_decode",  16'b0_0_0_0_0_00_01_01_00_000);
      chk("lw_memadr",  16'b0_0_0_0_0_00_10_01_00_000);
      chk("lw_rstall0", 16'b0_1_0_0_0_00_00_00_00_000);
      chk("lw_rstall1", 16'b0_1_0_0_0_00_00_00_00_000);
      chk("lw_rstall2", 16'b0_1_0_0_0_00_00_00_00_000);
      bus.mem_ready = 1'b1;
      chk("lw_memread", 16'b0_1_0_0_0_00_00_00_00_000);
      bus.mem_ready = 1'b0;
      chk("lw_memwb",   16'b0_0_0_0_1_01_00_00_00_000);
      bus.mem_ready = 1'b1;

      // sw with one MEMWRITE stall
      set_instr(7'b0100011, 3'b010, 1'b0);
      chk("sw_fetch",   16'b1_0_0_1_0_10_00_10_01_000);
      chk("sw_decode",  16'b0_0_0_0_0_00_01_01_01_000);
      chk("sw_memadr",  16'b0_0_0_0_0_00_10_01_01_000);
      bus.mem_ready = 1'b0;
      chk("sw_wstall",  16'b0_1_1_0_0_00_00_00_01_000);
      bus.mem_ready = 1'b1;
      chk("sw_memwr",   16'b0_1_1_0_0_00_00_00_01_000);

      // jal
      set_instr(7'b1101111, 3'b000, 1'b0);
      chk("jal_fetch",  16'b1_0_0_1_0_10_00_10_11_000);
      chk("jal_decode", 16'b0_0_0_0_0_00_01_01_11_000);
      chk("jal_jal",    16'b1_0_0_0_0_00_01_10_11_000);
      chk("jal_aluwb",  16'b0_0_0_0_1_00_00_00_11_000);

      // I-type decode, funct7b5 set (must not turn addi into sub)
      for (int i = 0; i < 4; i++) begin
         set_instr(7'b0010011, it_tab[i].f3, 1'b1);
         chk($sformatf("it%0d_fetch", i),  16'b1_0_0_1_0_10_00_10_00_000);
         chk($sformatf("it%0d_decode", i), 16'b0_0_0_0_0_00_01_01_00_000);
         chk($sformatf("it%0d_execi", i),  {13'b0_0_0_0_0_00_10_01_00, it_tab[i].alu});
         chk($sformatf("it%0d_aluwb", i),  16'b0_0_0_0_1_00_00_00_00_000);
      end

      // Unsupported opcode: 2 cycles, no write enables
      set_instr(7'b0000000, 3'b000, 1'b0);
      chk("nop_fetch",  16'b1_0_0_1_0_10_00_10_00_000);
      chk("nop_decode", 16'b0_0_0_0_0_00_01_01_00_000);

      // Reset asserted mid-MEMREAD, observed before any further clock edge
      set_instr(7'b0000011, 3'b010, 1'b0);
      chk("rlw_fetch",  16'b1_0_0_1_0_10_00_10_00_000);
      chk("rlw_decode", 16'b0_0_0_0_0_00_01_01_00_000);
      chk("rlw_memadr", 16'b0_0_0_0_0_00_10_01_00_000);
      bus.mem_ready = 1'b0;
      chk("rlw_memrd",  16'b0_1_0_0_0_00_00_00_00_000);
      rst_n = 1'b0;
      chk("rlw_reset",  16'b0_0_0_0_0_10_00_10_00_000);
      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;
      chk("rlw_refetch", 16'b1_0_0_1_0_10_00_10_00_000);
      chk("rlw_redecode", 16'b0_0_0_0_0_00_01_01_00_000);

      @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

endmodule
